// File: rtl/p_cacheline_burst_adapter.sv
// Cache-line to memory-burst adapter: splits 256-bit line reads/writes from the
// cache pmem port into four 64-bit beats on the physical memory bus.
module p_cacheline_burst_adapter #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int s_offset  = 5,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int cnt_w = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state_reg, state_next;
    logic [cnt_w-1:0]   cnt_reg;
    logic [31:0]        addr_reg;
    logic [s_line-1:0]  wbuf_reg;
    logic [s_burst-1:0] rbeat_reg [num_beats];
    logic [s_burst-1:0] wbeat     [num_beats];
    logic               beat_last;

    assign beat_last = resp_i && (cnt_reg == cnt_w'(num_beats - 1));

    // Per-beat views of the write buffer and per-beat read capture registers.
    for (genvar gi = 0; gi < num_beats; gi++) begin : g_beat
        assign wbeat[gi] = wbuf_reg[gi*s_burst +: s_burst];
        assign line_o[gi*s_burst +: s_burst] = rbeat_reg[gi];

        always_ff @(posedge clk) begin
            if (!rst) begin
                rbeat_reg[gi] <= '0;
            end else if (state_reg == READ && resp_i && cnt_reg == cnt_w'(gi)) begin
                rbeat_reg[gi] <= burst_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // A simultaneous read and write is resolved as a write.
                if (write_i)     state_next = WRITE;
                else if (read_i) state_next = READ;
            end
            READ:    if (beat_last) state_next = DONE;
            WRITE:   if (beat_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg  <= '0;
            addr_reg <= '0;
            wbuf_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (write_i) wbuf_reg <= line_i;
                    if (write_i || read_i) addr_reg <= address_i & addr_mask;
                end
                READ, WRITE: begin
                    // Power-of-two beat count lets the counter wrap to 0 on its own.
                    if (resp_i) cnt_reg <= cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_o    = (state_reg == READ);
        write_o   = (state_reg == WRITE);
        resp_o    = (state_reg == DONE);
        address_o = addr_reg;
        burst_o   = (state_reg == WRITE) ? wbeat[cnt_reg] : '0;
    end

endmodule

// File: tb/tb_p_cacheline_burst_adapter.sv
// Scoreboard bench for p_cacheline_burst_adapter: directed line reads/writes
// with a monitor checking every beat and every completion against queues.
module tb_p_cacheline_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    typedef struct packed {
        logic         is_read;
        logic [255:0] line;
    } resp_t;

    resp_t       exp_q[$];
    logic [63:0] beat_q[$];
    logic [31:0] exp_addr;
    int          checks   = 0;
    int          failures = 0;
    int          resp_cnt = 0;
    int          read_cycles = 0;

    p_cacheline_burst_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (read_o) read_cycles++;
            if ((read_o || write_o) && resp_i)
                check("beat_address", 256'(address_o), 256'(exp_addr));
            if (write_o) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 256'(1), 256'(0));
                end else if (resp_i) begin
                    check("write_beat", 256'(burst_o), 256'(beat_q.pop_front()));
                end else begin
                    check("write_beat_hold", 256'(burst_o), 256'(beat_q[0]));
                end
            end
            if (resp_o) begin
                resp_t e;
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 256'(1), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) check("read_line", line_o, e.line);
                    else           check("write_resp_no_read", 256'(read_o), 256'(0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] data,
                           input int waits, input bit expect_resp, input bit stray_done);
        resp_t e;
        e.is_read = 1'b1;
        e.line    = data;
        exp_q.push_back(e);
        exp_addr  = addr & 32'hFFFF_FFE0;
        address_i = addr;
        read_i    = 1'b1;
        tick();
        address_i = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            repeat (waits) begin
                resp_i  = 1'b0;
                burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
                tick();
            end
            resp_i  = 1'b1;
            burst_i = data[k*64 +: 64];
            tick();
        end
        resp_i  = stray_done;
        burst_i = 64'hFFFF_0000_FFFF_0000;
        if (expect_resp) begin
            check("read_resp_cycle", 256'(resp_o), 256'(1));
            check("read_o_dropped", 256'(read_o), 256'(0));
        end
        read_i = 1'b0;
        tick();
        resp_i = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                            input int waits, input bit also_read);
        resp_t e;
        e.is_read = 1'b0;
        e.line    = '0;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) beat_q.push_back(data[k*64 +: 64]);
        exp_addr  = addr & 32'hFFFF_FFE0;
        address_i = addr;
        line_i    = data;
        write_i   = 1'b1;
        read_i    = also_read;
        tick();
        line_i    = {4{64'h5555_AAAA_5555_AAAA}};
        address_i = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            repeat (waits) begin
                resp_i = 1'b0;
                tick();
            end
            resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        check("write_resp_cycle", 256'(resp_o), 256'(1));
        check("write_o_dropped", 256'(write_o), 256'(0));
        write_i = 1'b0;
        read_i  = 1'b0;
        tick();
        tick();
    endtask

    logic [255:0] line_a, line_b, line_c, line_d, line_w;
    int           rc0;

    initial begin
        rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0; exp_addr = '0;
        line_a = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        line_b = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                  64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
        line_c = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        line_d = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h1111_2222_3333_4444, 64'h9999_8888_7777_6666};
        line_w = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        repeat (2) tick();
        check("reset_line_o", line_o, '0);
        check("reset_ctrl", 256'({read_o, write_o, resp_o}), 256'(0));
        check("reset_burst_addr", 256'({burst_o, address_o}), 256'(0));
        rst = 1'b1;
        tick();

        // 1: zero-wait read; exact resp cycle checked inside the task
        do_read(32'h0000_1234, line_a, 0, 1'b1, 1'b0);
        $display("txn read  addr=00001234 line=%h", line_o);

        // 2: write with two wait states between beats
        do_write(32'h0000_4008, line_w, 2, 1'b0);
        $display("txn write addr=00004008 waits=2");
        check("line_o_kept_after_write", line_o, line_a);

        // 3: simultaneous read and write acts as write only
        rc0 = read_cycles;
        do_write(32'h0000_8000, line_d, 0, 1'b1);
        check("no_read_on_both", 256'(read_cycles - rc0), 256'(0));
        $display("txn write+read addr=00008000");

        // 4: reset mid-read after two beats
        exp_addr  = 32'h0000_2220;
        address_i = 32'h0000_2222;
        read_i    = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            resp_i = 1'b1; burst_i = line_c[k*64 +: 64];
            tick();
        end
        rst = 1'b0; resp_i = 1'b0; read_i = 1'b0;
        tick();
        check("midreset_ctrl", 256'({read_o, resp_o}), 256'(0));
        check("midreset_line_o", line_o, '0);
        rst = 1'b1;
        tick();
        do_read(32'h0000_2222, line_c, 1, 1'b1, 1'b0);
        $display("txn read after reset line=%h", line_o);

        // 5: write-back miss: write then read back to back
        do_write(32'h0001_0010, line_d, 0, 1'b0);
        check("wb_line_untouched", line_o, line_c);
        do_read(32'h0002_003F, line_b, 0, 1'b1, 1'b0);
        $display("txn writeback+read line=%h", line_o);

        // 6: stray resp_i in IDLE and in DONE
        resp_i = 1'b1; burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
        repeat (2) tick();
        resp_i = 1'b0;
        check("stray_idle_line", line_o, line_b);
        check("stray_idle_ctrl", 256'({read_o, write_o, resp_o}), 256'(0));
        do_read(32'h0003_0000, line_d, 0, 1'b1, 1'b1);
        check("stray_done_line", line_o, line_d);
        do_read(32'h0003_0020, line_a, 0, 1'b1, 1'b0);
        $display("txn stray resp checks line=%h", line_o);

        repeat (2) tick();
        check("resp_count", 256'(resp_cnt), 256'(8));
        check("exp_q_empty", 256'(exp_q.size()), 256'(0));
        check("beat_q_empty", 256'(beat_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p_cacheline_burst_adapter.md
Name: p_cacheline_burst_adapter

Overview:
Converts 256-bit cache-line transactions from the pipelined cache's pmem port into 4-beat, 64-bit bursts on the physical memory bus. It sits directly downstream of the cache's pmem_* interface. Read bursts are assembled into a full line. Write lines are serialized into beats. A single resp_o pulse to the cache marks completion of each transaction.

Parameters:
s_line, 256, cache line width in bits
s_burst, 64, memory beat width in bits
s_offset, 5, line offset bits; the address is line-aligned by zeroing [s_offset-1:0]
num_beats, s_line/s_burst (4), beats per line; must be a power of two

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge)
line_i  in  256  write line from cache (pmem_wdata)
line_o  out  256  read line to cache (pmem_rdata)
address_i  in  32  line address from cache (pmem_address)
read_i  in  1  line read request, held until resp_o
write_i  in  1  line write request, held until resp_o
resp_o  out  1  one-cycle completion pulse to cache (pmem_resp)
burst_i  in  64  read beat from memory
burst_o  out  64  write beat to memory
address_o  out  32  line-aligned burst address to memory
read_o  out  1  burst read request
write_o  out  1  burst write request
resp_i  in  1  memory beat acknowledge, one per beat

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, beat counter=0.
  - line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
  - Applies in any state. An in-flight burst is abandoned and no resp_o is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1: latch line_i into the write buffer, latch {address_i[31:5],5'b0}, go to WRITE.
  - else read_i=1: latch the aligned address, go to READ.
  - Both asserted: illegal input; treated as a write, read ignored.
- READ:
  - read_o=1 and address_o stable every cycle in state.
  - Each cycle with resp_i=1: line_o[64k+63:64k] <= burst_i for k=counter, then counter++.
  - When the beat with counter=3 is accepted: read_o drops the next cycle, counter wraps to 0, go to DONE.
  - resp_i=0 cycles are wait states; no update occurs.
- WRITE:
  - write_o=1, burst_o = buffer[64k+63:64k] for k=counter, updated combinationally from the counter.
  - Each resp_i=1 advances counter; after beat 3, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then go to IDLE.
  - read_i/write_i are ignored in DONE. The requester must deassert them on the cycle after resp_o.
  - A new request is accepted no earlier than 2 cycles after the resp_o cycle.
- line_o holds its last assembled value until the next read completes. It is valid whenever resp_o=1 after a read.
- Latency:
  - Request visible in IDLE -> read_o/write_o high the next cycle.
  - 4th resp_i -> resp_o the next cycle.
  - Minimum read latency is 6 cycles from request to resp_o (1 accept + 4 beats + 1 done).
- resp_i outside READ/WRITE is ignored; no counter change, no data capture.
- address_i, line_i changes after acceptance do not affect the in-flight burst.
- Beat order is always 0,1,2,3 (no critical-word-first).

Test Plan:
1. Read, zero-wait memory:
   - Stimulus: read_i=1, address_i=32'h0000_1234; memory returns beats 64'hA0, A1, A2, A3 with resp_i on 4 consecutive cycles.
   - Required: address_o=32'h0000_1220; line_o={A3,A2,A1,A0}; resp_o high exactly once, cycle 6.
2. Write with wait states:
   - Stimulus: write_i=1, line_i=256'h{D3,D2,D1,D0}; resp_i inserts 2 idle cycles between each beat.
   - Required: burst_o steps D0->D1->D2->D3, holding each value until its resp_i; write_o=0 after beat 3; one resp_o.
3. Simultaneous read_i and write_i in IDLE:
   - Required: write burst performed, read_o never asserted, single resp_o.
4. Reset mid-read:
   - Stimulus: rst=0 after 2 of 4 beats.
   - Required: next cycle read_o=0, resp_o=0, line_o=0. A subsequent read completes normally with counter starting at beat 0.
5. Back-to-back write then read, the write-back miss sequence:
   - Required: the read is accepted only after DONE->IDLE; no beat from the write is captured into line_o.
6. Stray resp_i in IDLE and DONE:
   - Required: no state, counter, or line_o change.
